pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter LU_STALL_CYCLES, default 1, load-use stall length in cycles; legal range 1..3.
REQ-002 SHALL have parameter CNT_W, default 32, width of the performance counters.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port lu_hazard  input  1  load-use hazard between the ID operands and the EX load destination.
REQ-006 SHALL have port br_taken  input  1  EX-stage branch or jump redirect.
REQ-007 SHALL have ports md_busy, dmem_wait, imem_wait  input  1 each; multi-cycle EX unit busy, data memory not ready, instruction memory not ready.
REQ-008 SHALL have ports pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  output  1 each  stage-register load enables.
REQ-009 SHALL have ports if_id_flush, id_ex_flush, ex_mem_flush  output  1 each  bubble insertion into the named register.
REQ-010 SHALL have ports stall_cnt, flush_cnt  output  CNT_W each  performance counters; present only under PERF_CNT_EN.

Function
REQ-011 SHALL implement the FSM states RUN and LU_STALL, with combinational (Mealy) outputs from state and inputs.
REQ-012 SHALL default every output to enable=1 and flush=0 when no condition in REQ-013..REQ-017 applies.
REQ-013 Priority 1, dmem_wait=1: all enables 0, all flushes 0, FSM state and lu_cnt held.
REQ-014 Priority 2, br_taken=1: if_id_flush=id_ex_flush=1 and all enables 1; the next state is RUN and lu_cnt is cleared, cancelling any pending load-use stall.
REQ-015 Priority 3, md_busy=1: pc_en=if_id_en=id_ex_en=ex_mem_en=0, ex_mem_flush=1 (the flush overrides the hold and inserts a bubble), mem_wb_en=1; FSM state held.
REQ-016 Priority 4, lu_hazard=1 in RUN, or state LU_STALL: pc_en=if_id_en=0 and id_ex_flush=1.
- Entry from RUN with LU_STALL_CYCLES=1: stay in RUN.
- Entry from RUN with LU_STALL_CYCLES>1: load lu_cnt=LU_STALL_CYCLES-1 and enter LU_STALL.
- In LU_STALL: decrement lu_cnt each non-frozen cycle; return to RUN on the cycle lu_cnt reaches 0, whatever lu_hazard is.
REQ-017 Priority 5, imem_wait=1: pc_en=0, and if_id_en=1 with if_id_flush=1 inserts a fetch bubble.
REQ-018 SHALL make lu_cnt 2 bits wide; a flush and a stall in the same cycle resolve strictly by REQ-013..REQ-017 priority.

Reset
REQ-019 SHALL on rst=1 at a clock edge enter RUN, clear lu_cnt, and clear both counters; this overrides any stall in progress.
REQ-020 SHALL hold the outputs in the REQ-012 defaults while rst=1.

Configuration
REQ-021 With PERF_CNT_EN defined:
- stall_cnt increments by 1 on each cycle in which pc_en=0.
- flush_cnt increments by 1 on each cycle in which br_taken applies per REQ-014.
- Both counters saturate at all-ones.
REQ-022 Without PERF_CNT_EN: the counters, their logic and their ports are absent.

Structure
REQ-023 SHALL take the state enum, the LU_CNT_W=2 constant and the default CNT_W from shared package pipe_ctrl_pkg.
REQ-024 SHALL instantiate sub-module sat_counter (parameter width; ports inc, clr, q) once per performance counter.

Verification
REQ-025 lu_hazard=1 for one cycle, LU_STALL_CYCLES=1 -> pc_en=if_id_en=0 and id_ex_flush=1 for exactly 1 cycle, then defaults.
REQ-026 LU_STALL_CYCLES=3, lu_hazard pulse, then br_taken on the 2nd stall cycle -> if_id_flush=id_ex_flush=1 that cycle, state RUN next cycle, no third stall cycle.
REQ-027 dmem_wait=1 for 4 cycles during an LU_STALL -> all enables 0 for 4 cycles, lu_cnt unchanged; the stall resumes afterwards with its remaining count.
REQ-028 md_busy=1 for 5 cycles -> ex_mem_flush=1, mem_wb_en=1, upstream enables 0 for 5 cycles; with PERF_CNT_EN, stall_cnt=5.
REQ-029 imem_wait and lu_hazard together -> load-use outputs take priority, if_id_en=0; rst asserted mid-stall -> RUN and defaults on the next cycle.
REQ-030 With PERF_CNT_EN and CNT_W=4: 20 consecutive stall cycles -> stall_cnt holds 4'hF.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

    localparam int LU_CNT_W      = 2;
    localparam int CNT_W_DEFAULT = 32;

    typedef enum logic {
        RUN      = 1'b0,
        LU_STALL = 1'b1
    } pipe_state_e;

    // The first stall cycle is spent in RUN, so the remaining count is one less.
    function automatic logic [LU_CNT_W-1:0] lu_cnt_init(input int stall_cycles);
        return LU_CNT_W'(stall_cycles - 1);
    endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs and stage-register controls between the datapath and the controller.
interface pipeline_ctrl_if;

    logic lu_hazard;
    logic br_taken;
    logic md_busy;
    logic dmem_wait;
    logic imem_wait;

    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_flush;

    modport master (
        input  lu_hazard, br_taken, md_busy, dmem_wait, imem_wait,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
        output if_id_flush, id_ex_flush, ex_mem_flush
    );

    modport slave (
        output lu_hazard, br_taken, md_busy, dmem_wait, imem_wait,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
        input  if_id_flush, id_ex_flush, ex_mem_flush
    );

endinterface

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             inc,
    input  logic             clr,
    output logic [width-1:0] q
);

    logic [width-1:0] q_q;
    logic [width-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (inc && (q_q != {width{1'b1}})) begin
            q_d = q_q + width'(1);
        end
    end

    always_ff @(posedge clk) begin
        q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller with a multi-cycle load-use stall FSM.
// Define PERF_CNT_EN to add the stall_cnt / flush_cnt performance counters.
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int LU_STALL_CYCLES = 1,
    parameter int CNT_W           = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    pipeline_ctrl_if.master  ctl
`ifdef PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    pipe_state_e          state_q, state_d;
    logic [LU_CNT_W-1:0]  lu_cnt_q, lu_cnt_d;

    logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic if_id_flush, id_ex_flush, ex_mem_flush;
    logic br_apply;

    // Mealy decode: outputs follow the current state and this cycle's inputs.
    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        mem_wb_en    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        br_apply     = 1'b0;
        state_d      = state_q;
        lu_cnt_d     = lu_cnt_q;

        if (rst) begin
            state_d  = RUN;
            lu_cnt_d = '0;
        end else if (ctl.dmem_wait) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
        end else if (ctl.br_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            br_apply    = 1'b1;
            state_d     = RUN;
            lu_cnt_d    = '0;
        end else if (ctl.md_busy) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            ex_mem_flush = 1'b1;
        end else if ((ctl.lu_hazard && (state_q == RUN)) || (state_q == LU_STALL)) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
            if (state_q == RUN) begin
                if (LU_STALL_CYCLES > 1) begin
                    lu_cnt_d = lu_cnt_init(LU_STALL_CYCLES);
                    state_d  = LU_STALL;
                end
            end else begin
                lu_cnt_d = lu_cnt_q - LU_CNT_W'(1);
                if (lu_cnt_d == '0) begin
                    state_d = RUN;
                end
            end
        end else if (ctl.imem_wait) begin
            pc_en       = 1'b0;
            if_id_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        state_q  <= state_d;
        lu_cnt_q <= lu_cnt_d;
    end

    assign ctl.pc_en        = pc_en;
    assign ctl.if_id_en     = if_id_en;
    assign ctl.id_ex_en     = id_ex_en;
    assign ctl.ex_mem_en    = ex_mem_en;
    assign ctl.mem_wb_en    = mem_wb_en;
    assign ctl.if_id_flush  = if_id_flush;
    assign ctl.id_ex_flush  = id_ex_flush;
    assign ctl.ex_mem_flush = ex_mem_flush;

`ifdef PERF_CNT_EN
    sat_counter #(.width(CNT_W)) u_stall_cnt (
        .clk (clk),
        .inc (~pc_en),
        .clr (rst),
        .q   (stall_cnt)
    );

    sat_counter #(.width(CNT_W)) u_flush_cnt (
        .clk (clk),
        .inc (br_apply),
        .clr (rst),
        .q   (flush_cnt)
    );
`else
    logic unused_br_apply;
    assign unused_br_apply = br_apply;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: one DUT with a 1-cycle and one with a 3-cycle load-use stall.
// Counter checks are active when PERF_CNT_EN is defined.
module tb_pipeline_ctrl;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pipeline_ctrl_if if1 ();
    pipeline_ctrl_if if3 ();

`ifdef PERF_CNT_EN
    logic [3:0] stall1, flush1, stall3, flush3;
`endif

    pipeline_ctrl #(.LU_STALL_CYCLES(1), .CNT_W(4)) dut1 (
        .clk (clk),
        .rst (rst),
        .ctl (if1.master)
`ifdef PERF_CNT_EN
        ,
        .stall_cnt (stall1),
        .flush_cnt (flush1)
`endif
    );

    pipeline_ctrl #(.LU_STALL_CYCLES(3), .CNT_W(4)) dut3 (
        .clk (clk),
        .rst (rst),
        .ctl (if3.master)
`ifdef PERF_CNT_EN
        ,
        .stall_cnt (stall3),
        .flush_cnt (flush3)
`endif
    );

    // {pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush, ex_mem_flush}
    localparam logic [7:0] DEF  = 8'b11111_000;
    localparam logic [7:0] DMEM = 8'b00000_000;
    localparam logic [7:0] BR   = 8'b11111_110;
    localparam logic [7:0] MD   = 8'b00001_001;
    localparam logic [7:0] LU   = 8'b00111_010;
    localparam logic [7:0] IM   = 8'b01111_100;

    // {rst, lu_hazard, br_taken, md_busy, dmem_wait, imem_wait}
    localparam logic [5:0] V_IDLE = 6'b000000;
    localparam logic [5:0] V_RST  = 6'b100000;
    localparam logic [5:0] V_LU   = 6'b010000;
    localparam logic [5:0] V_BR   = 6'b001000;
    localparam logic [5:0] V_MD   = 6'b000100;
    localparam logic [5:0] V_DM   = 6'b000010;
    localparam logic [5:0] V_IM   = 6'b000001;

    wire [7:0] out1 = {if1.pc_en, if1.if_id_en, if1.id_ex_en, if1.ex_mem_en, if1.mem_wb_en,
                       if1.if_id_flush, if1.id_ex_flush, if1.ex_mem_flush};
    wire [7:0] out3 = {if3.pc_en, if3.if_id_en, if3.id_ex_en, if3.ex_mem_en, if3.mem_wb_en,
                       if3.if_id_flush, if3.id_ex_flush, if3.ex_mem_flush};

    typedef struct {
        logic [7:0] e1;
        logic [7:0] e3;
        logic       cc;
        int         es;
        int         ef;
        string      nm;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;

    task automatic step(input logic [5:0] v, input logic [7:0] e1, input logic [7:0] e3,
                        input string nm, input logic cc = 1'b0, input int es = 0, input int ef = 0);
        exp_t e;
        @(posedge clk);
        #1;
        rst           = v[5];
        if1.lu_hazard = v[4]; if3.lu_hazard = v[4];
        if1.br_taken  = v[3]; if3.br_taken  = v[3];
        if1.md_busy   = v[2]; if3.md_busy   = v[2];
        if1.dmem_wait = v[1]; if3.dmem_wait = v[1];
        if1.imem_wait = v[0]; if3.imem_wait = v[0];
        e.e1 = e1; e.e3 = e3; e.cc = cc; e.es = es; e.ef = ef; e.nm = nm;
        sb.push_back(e);
    endtask

    // Monitor: every cycle presents a control word; compare on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                $display("txn %-10s d1=%b d3=%b", e.nm, out1, out3);
                total++;
                if (out1 !== e.e1) begin
                    bad++;
                    $display("FAIL %s lu1 got=%b want=%b", e.nm, out1, e.e1);
                end
                total++;
                if (out3 !== e.e3) begin
                    bad++;
                    $display("FAIL %s lu3 got=%b want=%b", e.nm, out3, e.e3);
                end
`ifdef PERF_CNT_EN
                if (e.cc) begin
                    total++;
                    if (stall1 !== 4'(e.es) || stall3 !== 4'(e.es)) begin
                        bad++;
                        $display("FAIL %s stall_cnt got=%0d/%0d want=%0d", e.nm, stall1, stall3, e.es);
                    end
                    total++;
                    if (flush1 !== 4'(e.ef) || flush3 !== 4'(e.ef)) begin
                        bad++;
                        $display("FAIL %s flush_cnt got=%0d/%0d want=%0d", e.nm, flush1, flush3, e.ef);
                    end
                end
`endif
            end
        end
    end

    initial begin
        rst = 1'b1;
        if1.lu_hazard = 1'b0; if1.br_taken = 1'b0; if1.md_busy = 1'b0;
        if1.dmem_wait = 1'b0; if1.imem_wait = 1'b0;
        if3.lu_hazard = 1'b0; if3.br_taken = 1'b0; if3.md_busy = 1'b0;
        if3.dmem_wait = 1'b0; if3.imem_wait = 1'b0;

        step(V_RST,                DEF, DEF, "rst");
        step(V_RST | V_LU | V_DM,  DEF, DEF, "rst_dflt");
        step(V_IDLE,               DEF, DEF, "idle");

        // Single load-use pulse
        step(V_LU,   LU,  LU,  "lu_s1");
        step(V_IDLE, DEF, LU,  "lu_s2");
        step(V_IDLE, DEF, LU,  "lu_s3");
        step(V_IDLE, DEF, DEF, "lu_done");

        // Branch cancels the pending stall
        step(V_LU,   LU,  LU,  "lu_br1");
        step(V_BR,   BR,  BR,  "br_cancel");
        step(V_IDLE, DEF, DEF, "no_3rd");

        // Data-memory freeze in the middle of a stall
        step(V_LU,   LU,  LU,  "lu_dm1");
        step(V_IDLE, DEF, LU,  "lu_dm2");
        for (int i = 0; i < 4; i++) step(V_DM, DMEM, DMEM, "dm_frz");
        step(V_IDLE, DEF, LU,  "resume");
        step(V_IDLE, DEF, DEF, "dm_done");

        // Multi-cycle unit busy
        step(V_RST, DEF, DEF, "rst_md");
        for (int i = 0; i < 5; i++) step(V_MD, MD, MD, "md_busy");
        step(V_IDLE, DEF, DEF, "md_cnt", 1'b1, 5, 0);

        // md_busy freezes the stall counter
        step(V_LU,   LU,  LU,  "lu_md1");
        step(V_MD,   MD,  MD,  "md_in_lu");
        step(V_IDLE, DEF, LU,  "lu_md2");
        step(V_IDLE, DEF, LU,  "lu_md3");
        step(V_IDLE, DEF, DEF, "lu_md_done");

        // Fetch wait vs load-use, then reset mid-stall
        step(V_IM | V_LU, LU,  LU,  "im_lu");
        step(V_IDLE,      DEF, LU,  "im_lu2");
        step(V_RST,       DEF, DEF, "rst_mid");
        step(V_IDLE,      DEF, DEF, "post_rst");

        // Priority combinations
        step(V_IM,        IM,   IM,   "imem");
        step(V_BR | V_MD, BR,   BR,   "br_md");
        step(V_DM | V_BR, DMEM, DMEM, "dm_br");
        step(V_MD | V_LU, MD,   MD,   "md_lu");
        step(V_IDLE,      DEF,  DEF,  "idle2");
        step(V_MD | V_IM, MD,   MD,   "md_im");
        step(V_BR | V_LU, BR,   BR,   "br_lu");
        step(V_IDLE,      DEF,  DEF,  "prio_cnt", 1'b1, 4, 2);

        // Counter saturation
        step(V_RST, DEF, DEF, "rst_sat");
        for (int i = 0; i < 20; i++) step(V_MD, MD, MD, "md_sat");
        step(V_IDLE, DEF, DEF, "sat_cnt", 1'b1, 15, 0);

        @(posedge clk);
        @(negedge clk);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_drain got=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
